// File: rtl/histo_frame_ctrl_pkg.sv
// Shared types and helpers for the histogram frame sequencer: state encoding,
// bin geometry and saturating count arithmetic.
package histo_frame_ctrl_pkg;

   typedef enum logic [2:0] {
      HF_IDLE  = 3'd0,
      HF_CLEAR = 3'd1,
      HF_WAIT  = 3'd2,
      HF_ACCUM = 3'd3,
      HF_DRAIN = 3'd4,
      HF_SCAN  = 3'd5,
      HF_DONE  = 3'd6
   } hf_state_e;

   localparam int HIST_BINS  = 256;
   localparam int HIST_CNT_W = 20;
   localparam logic [HIST_CNT_W-1:0] HIST_CNT_MAX = '1;

   function automatic logic [HIST_CNT_W-1:0] sat_inc(input logic [HIST_CNT_W-1:0] a);
      return (a == HIST_CNT_MAX) ? a : a + HIST_CNT_W'(1);
   endfunction

   function automatic logic [HIST_CNT_W-1:0] sat_add(input logic [HIST_CNT_W-1:0] a,
                                                     input logic [HIST_CNT_W-1:0] b);
      logic [HIST_CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[HIST_CNT_W] ? HIST_CNT_MAX : s[HIST_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/histo_frame_ctrl_rmw.sv
// Read-modify-write increment path for the bin RAM: the read is issued by the
// caller, the increment happens one cycle later with forwarding of the last write.
module histo_rmw_pipe
   import histo_frame_ctrl_pkg::*;
#(
   parameter int BIN_W = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_vld,
   input  logic [BIN_W-1:0]      i_addr,
   input  logic [HIST_CNT_W-1:0] i_q,
   output logic                  o_wen,
   output logic [BIN_W-1:0]      o_waddr,
   output logic [HIST_CNT_W-1:0] o_wdata,
   output logic                  o_sat
);

   logic                  r_vld_p1;
   logic [BIN_W-1:0]      r_addr_p1;
   logic                  r_vld_p2;
   logic [BIN_W-1:0]      r_addr_p2;
   logic [HIST_CNT_W-1:0] r_data_p2;
   logic                  w_fwd;
   logic [HIST_CNT_W-1:0] w_base;
   logic [HIST_CNT_W-1:0] w_inc;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
      end else begin
         r_vld_p1 <= i_vld;
         r_vld_p2 <= r_vld_p1;
      end
   end

   always_ff @(posedge i_clk) begin
      r_addr_p1 <= i_addr;
      r_addr_p2 <= r_addr_p1;
      r_data_p2 <= w_inc;
   end

   // stage 1: the write issued last cycle lands in RAM on the same edge our read
   // was sampled, so the RAM returned stale data for a back-to-back same bin
   assign w_fwd   = r_vld_p2 && (r_addr_p2 == r_addr_p1);
   assign w_base  = w_fwd ? r_data_p2 : i_q;
   assign w_inc   = sat_inc(w_base);

   assign o_wen   = r_vld_p1;
   assign o_waddr = r_addr_p1;
   assign o_wdata = w_inc;
   assign o_sat   = r_vld_p1 && (w_base == HIST_CNT_MAX);

endmodule

// File: rtl/histo_frame_ctrl.sv
// Frame sequencer for the histogram bin RAM: clear, accumulate grey pixels,
// then scan bins into the display copy RAMs while clearing them for the next frame.
module histo_frame_ctrl
   import histo_frame_ctrl_pkg::*;
#(
   parameter int BIN_W = $clog2(HIST_BINS),
   parameter int CNT_W = HIST_CNT_W
) (
   input  logic             iPclk,
   input  logic             iRst,
   input  logic             iFval,
   input  logic             iDval,
   input  logic [BIN_W-1:0] iGrey,
   output logic [BIN_W-1:0] oRamRdAddr,
   input  logic [CNT_W-1:0] iRamQ,
   output logic [BIN_W-1:0] oRamWrAddr,
   output logic [CNT_W-1:0] oRamWrData,
   output logic             oRamWen,
   output logic             oCopyWen,
   output logic [BIN_W-1:0] oCopyAddr,
   output logic [CNT_W-1:0] oCopyHist,
   output logic [CNT_W-1:0] oCopyCum,
   output logic [CNT_W-1:0] oTotal,
   output logic [CNT_W-1:0] oPeak,
   output logic             oFrameDone,
   output logic             oSkip,
   output logic             oOverflow,
   output logic [2:0]       oState
);

   localparam logic [BIN_W:0] LAST_BIN  = (BIN_W+1)'((1 << BIN_W) - 1);
   localparam logic [BIN_W:0] LAST_SCAN = (BIN_W+1)'(1 << BIN_W);

   hf_state_e        r_state;
   hf_state_e        w_nxt;
   logic [BIN_W:0]   r_cnt;
   logic             r_fval_d;
   logic             w_rise;
   logic             w_acc_vld;
   logic             w_acc_wen;
   logic [BIN_W-1:0] w_acc_addr;
   logic [CNT_W-1:0] w_acc_data;
   logic             w_acc_sat;
   logic             r_clr_wen;
   logic [BIN_W-1:0] r_clr_addr;
   logic             w_scan_dv;
   logic [BIN_W-1:0] w_scan_bin;
   logic [CNT_W-1:0] r_cum;
   logic [CNT_W-1:0] r_peak;
   logic [CNT_W-1:0] w_cum_nxt;
   logic [CNT_W-1:0] w_peak_nxt;
   logic             w_cum_ovf;
   logic [CNT_W-1:0] r_total;
   logic [CNT_W-1:0] r_pk;
   logic             r_ovf;
   logic             r_skip;

   assign w_rise    = iFval && !r_fval_d;
   assign w_acc_vld = iFval && iDval &&
                      ((r_state == HF_ACCUM) || ((r_state == HF_WAIT) && w_rise));

   histo_rmw_pipe #(.BIN_W(BIN_W)) u_rmw (
      .i_clk   (iPclk),
      .i_rst   (iRst),
      .i_vld   (w_acc_vld),
      .i_addr  (iGrey),
      .i_q     (iRamQ),
      .o_wen   (w_acc_wen),
      .o_waddr (w_acc_addr),
      .o_wdata (w_acc_data),
      .o_sat   (w_acc_sat)
   );

   always_ff @(posedge iPclk) begin
      if (iRst) r_state <= HF_CLEAR;
      else      r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         HF_CLEAR: if (r_cnt == LAST_BIN)  w_nxt = HF_WAIT;
         HF_WAIT:  if (w_rise)             w_nxt = HF_ACCUM;
         HF_ACCUM: if (!iFval)             w_nxt = HF_DRAIN;
         HF_DRAIN:                         w_nxt = HF_SCAN;
         HF_SCAN:  if (r_cnt == LAST_SCAN) w_nxt = HF_DONE;
         HF_DONE:                          w_nxt = HF_WAIT;
         default:                          w_nxt = HF_CLEAR;
      endcase
   end

   always_ff @(posedge iPclk) begin
      if (iRst)                                          r_cnt <= '0;
      else if (w_nxt != r_state)                         r_cnt <= '0;
      else if ((r_state == HF_CLEAR) || (r_state == HF_SCAN)) r_cnt <= r_cnt + (BIN_W+1)'(1);
      else                                               r_cnt <= '0;
   end

   // scan: cycle k reads bin k, cycle k+1 consumes it, so data lags the counter by one
   assign w_scan_dv  = (r_state == HF_SCAN) && (r_cnt != '0);
   assign w_scan_bin = BIN_W'(r_cnt - (BIN_W+1)'(1));
   assign w_cum_nxt  = sat_add(r_cum, iRamQ);
   assign w_cum_ovf  = iRamQ > ~r_cum;
   assign w_peak_nxt = (iRamQ > r_peak) ? iRamQ : r_peak;

   always_ff @(posedge iPclk) begin
      r_fval_d <= iFval;
      if (r_state == HF_DRAIN) begin
         r_cum  <= '0;
         r_peak <= '0;
      end else if (w_scan_dv) begin
         r_cum  <= w_cum_nxt;
         r_peak <= w_peak_nxt;
      end
   end

   always_ff @(posedge iPclk) begin
      if (iRst) begin
         r_clr_wen  <= 1'b0;
         r_clr_addr <= '0;
         r_skip     <= 1'b0;
         r_ovf      <= 1'b0;
         r_total    <= '0;
         r_pk       <= '0;
      end else begin
         r_clr_wen  <= (r_state == HF_CLEAR);
         r_clr_addr <= BIN_W'(r_cnt);
         r_skip     <= w_rise && (r_state inside {HF_CLEAR, HF_DRAIN, HF_SCAN, HF_DONE});
         if ((r_state == HF_WAIT) && w_rise)             r_ovf <= 1'b0;
         else if (w_acc_sat || (w_scan_dv && w_cum_ovf)) r_ovf <= 1'b1;
         if ((r_state == HF_SCAN) && (r_cnt == LAST_SCAN)) begin
            r_total <= w_cum_nxt;
            r_pk    <= w_peak_nxt;
         end
      end
   end

   assign oRamRdAddr = w_acc_vld ? iGrey :
                       ((r_state == HF_SCAN) && (r_cnt <= LAST_BIN)) ? BIN_W'(r_cnt) : '0;
   assign oRamWen    = r_clr_wen | w_acc_wen | w_scan_dv;
   assign oRamWrAddr = r_clr_wen ? r_clr_addr :
                       w_acc_wen ? w_acc_addr :
                       w_scan_dv ? w_scan_bin : '0;
   assign oRamWrData = (w_acc_wen && !r_clr_wen) ? w_acc_data : '0;

   assign oCopyWen   = w_scan_dv;
   assign oCopyAddr  = w_scan_dv ? w_scan_bin : '0;
   assign oCopyHist  = w_scan_dv ? iRamQ : '0;
   assign oCopyCum   = w_scan_dv ? w_cum_nxt : '0;

   assign oTotal     = r_total;
   assign oPeak      = r_pk;
   assign oFrameDone = (r_state == HF_DONE);
   assign oSkip      = r_skip;
   assign oOverflow  = r_ovf;
   assign oState     = r_state;

endmodule

// File: tb/tb_histo_frame_ctrl.sv
// Scoreboard bench for histo_frame_ctrl: bin RAM model, per-frame histogram
// reference, and a monitor that checks accumulate writes, copy stream and frame results.
`timescale 1ns/1ps
module tb_histo_frame_ctrl;

   localparam int BW = 8;
   localparam int CW = 20;
   localparam int unsigned MAXI = (1 << CW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, fval, dval;
   logic [BW-1:0] grey, rd_addr, wr_addr, copy_addr;
   logic [CW-1:0] ram_q, wr_data, copy_hist, copy_cum, total, peak;
   logic          wen, copy_wen, fdone, skip, ovf;
   logic [2:0]    state;

   histo_frame_ctrl dut (
      .iPclk(clk), .iRst(rst), .iFval(fval), .iDval(dval), .iGrey(grey),
      .oRamRdAddr(rd_addr), .iRamQ(ram_q), .oRamWrAddr(wr_addr), .oRamWrData(wr_data),
      .oRamWen(wen), .oCopyWen(copy_wen), .oCopyAddr(copy_addr), .oCopyHist(copy_hist),
      .oCopyCum(copy_cum), .oTotal(total), .oPeak(peak), .oFrameDone(fdone),
      .oSkip(skip), .oOverflow(ovf), .oState(state)
   );

   // bin RAM: 1-cycle read, old data on read-during-write, plus a bench preload port
   logic [CW-1:0] mem [256];
   logic          pl_en;
   logic [BW-1:0] pl_addr;
   logic [CW-1:0] pl_val;
   always @(posedge clk) begin
      ram_q <= mem[rd_addr];
      if (wen)   mem[wr_addr] <= wr_data;
      if (pl_en) mem[pl_addr] <= pl_val;
   end

   typedef struct packed { logic [BW-1:0] a; logic [CW-1:0] v; } wr_t;
   typedef struct packed { logic [BW-1:0] a; logic [CW-1:0] h; logic [CW-1:0] c; } cp_t;
   typedef struct packed { logic [CW-1:0] t; logic [CW-1:0] p; logic o; } dn_t;

   wr_t exp_wr[$];
   cp_t exp_cp[$];
   dn_t exp_dn[$];
   int unsigned hist [256];
   logic [BW-1:0] pix_q[$];

   int n_tests = 0, n_fail = 0;
   int skip_cnt = 0, done_cnt = 0, n_frames = 0;
   bit chk_wr = 1'b1;
   wr_t e_wr;
   cp_t e_cp;
   dn_t e_dn;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor: pops an expectation whenever the DUT presents a transaction
   always @(negedge clk) begin
      if (!rst) begin
         if (skip) skip_cnt++;
         if (chk_wr && wen && state == 3'd3) begin
            if (exp_wr.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL accum_write: unexpected write addr %0d data %0d", wr_addr, wr_data);
            end else begin
               e_wr = exp_wr.pop_front();
               check("accum_write", {wr_addr, wr_data}, e_wr);
            end
         end
         if (copy_wen) begin
            if (exp_cp.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL copy_write: unexpected addr %0d hist %0d cum %0d", copy_addr, copy_hist, copy_cum);
            end else begin
               e_cp = exp_cp.pop_front();
               check("copy_write", {copy_addr, copy_hist, copy_cum}, e_cp);
            end
         end
         if (fdone) begin
            done_cnt++;
            if (exp_dn.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL frame_done: unexpected pulse total %0d peak %0d", total, peak);
            end else begin
               e_dn = exp_dn.pop_front();
               check("frame_result", {total, peak, ovf}, e_dn);
            end
         end
      end
   end

   task automatic wait_state(input logic [2:0] s, input string nm);
      int i;
      for (i = 0; i < 3000 && state != s; i++) tick();
      if (state != s) begin
         n_tests++; n_fail++;
         $display("FAIL %s: timeout, state %0d expected %0d", nm, state, s);
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3000 && done_cnt < n_frames; i++) tick();
      check("frame_done_count", done_cnt, n_frames);
      tick();
   endtask

   task automatic clear_check(input string nm);
      int n = 0, bad = 0;
      for (int i = 0; i < 300; i++) begin
         if (wen) begin
            if (wr_addr != BW'(n) || wr_data != '0) bad++;
            n++;
         end
         if (n > 0 && !wen && state == 3'd2) break;
         tick();
      end
      check({nm, "_len"}, n, 256);
      check({nm, "_addr_data"}, bad, 0);
      check({nm, "_state"}, state, 2);
   endtask

   // drives one frame from pix_q and queues the reference results
   task automatic run_frame(input bit gaps);
      int unsigned cum, pk;
      bit o = 1'b0;
      wait_state(3'd2, "frame_wait");
      fval = 1'b0; tick(); tick();
      fval = 1'b1;
      while (pix_q.size() > 0) begin
         if (!gaps || $urandom_range(0, 3) != 0) begin
            dval = 1'b1;
            grey = pix_q.pop_front();
            if (hist[grey] == MAXI) o = 1'b1;
            else                    hist[grey]++;
            exp_wr.push_back(wr_t'{a: grey, v: CW'(hist[grey])});
         end else begin
            dval = 1'b0;
            grey = BW'($urandom);
         end
         tick();
      end
      fval = 1'b0; dval = 1'($urandom_range(0, 1)); grey = BW'($urandom);
      cum = 0; pk = 0;
      for (int k = 0; k < 256; k++) begin
         if (cum + hist[k] > MAXI) begin cum = MAXI; o = 1'b1; end
         else cum = cum + hist[k];
         if (hist[k] > pk) pk = hist[k];
         exp_cp.push_back(cp_t'{a: BW'(k), h: CW'(hist[k]), c: CW'(cum)});
         hist[k] = 0;
      end
      exp_dn.push_back(dn_t'{t: CW'(cum), p: CW'(pk), o: o});
      n_frames++;
   endtask

   task automatic rand_pixels(input int n, input int maxg);
      for (int i = 0; i < n; i++) pix_q.push_back(BW'($urandom_range(0, maxg)));
   endtask

   initial begin
      rst = 1'b1; fval = 1'b0; dval = 1'b0; grey = '0;
      pl_en = 1'b0; pl_addr = '0; pl_val = '0;
      for (int k = 0; k < 256; k++) hist[k] = 0;
      repeat (3) tick();

      check("rst_state", state, 1);
      check("rst_ram_wr", {wen, wr_addr, wr_data}, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_copy", {copy_wen, copy_addr, copy_hist, copy_cum}, 0);
      check("rst_result", {total, peak}, 0);
      check("rst_flags", {fdone, skip, ovf}, 0);

      rst = 1'b0;
      clear_check("clear0");
      check("idle_outputs", {copy_wen, fdone, ovf, total, peak}, 0);

      // back-to-back same bin exercises forwarding
      pix_q = '{8'd5, 8'd5, 8'd5, 8'd7};
      run_frame(1'b0);
      wait_done();
      check("frame1_total", total, 4);
      check("frame1_peak", peak, 3);
      check("frame1_done_pulse", fdone, 0);

      for (int f = 0; f < 3; f++) begin
         rand_pixels(150, 15);
         run_frame(1'b1);
         wait_done();
      end

      pl_addr = 8'd9; pl_val = CW'(MAXI - 1); pl_en = 1'b1;
      tick();
      pl_en = 1'b0;
      hist[9] = MAXI - 1;
      pix_q = '{8'd9, 8'd9};
      run_frame(1'b0);
      wait_done();
      repeat (3) tick();
      check("ovf_sticky", ovf, 1);

      rand_pixels(120, 31);
      run_frame(1'b1);
      check("ovf_cleared", ovf, 0);

      // frame starting late in the scan and running into WAIT is rejected
      for (int i = 0; i < 600 && !(copy_wen && copy_addr == 8'd250); i++) tick();
      check("scan_reached", {copy_wen, copy_addr}, {1'b1, 8'd250});
      fval = 1'b1;
      for (int i = 0; i < 30; i++) begin
         dval = 1'($urandom_range(0, 1)); grey = BW'($urandom);
         tick();
      end
      check("skip_state_wait", state, 2);
      fval = 1'b0;
      wait_done();
      check("skip_count", skip_cnt, 1);

      rand_pixels(80, 255);
      run_frame(1'b1);
      wait_done();

      // reset in the middle of accumulation
      chk_wr = 1'b0;
      wait_state(3'd2, "rst_frame_wait");
      tick(); tick();
      fval = 1'b1;
      for (int i = 0; i < 20; i++) begin
         dval = 1'b1; grey = BW'($urandom_range(0, 7));
         tick();
      end
      rst = 1'b1; fval = 1'b0; dval = 1'b0;
      tick();
      check("midrst_state", state, 1);
      check("midrst_ram_wr", {wen, wr_addr, wr_data, rd_addr}, 0);
      check("midrst_copy", {copy_wen, copy_addr, copy_hist, copy_cum}, 0);
      check("midrst_result", {total, peak, ovf, fdone}, 0);
      rst = 1'b0;
      exp_wr.delete();
      chk_wr = 1'b1;
      clear_check("clear1");

      for (int i = 0; i < 100; i++) pix_q.push_back(8'd0);
      run_frame(1'b0);
      wait_done();
      check("grey0_total100", total, 100);
      for (int i = 0; i < 50; i++) pix_q.push_back(8'd0);
      run_frame(1'b1);
      wait_done();
      check("grey0_total50", total, 50);

      check("skip_count_end", skip_cnt, 1);
      check("queue_wr_empty", exp_wr.size(), 0);
      check("queue_cp_empty", exp_cp.size(), 0);
      check("queue_dn_empty", exp_dn.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
